// File: rtl/ttt_nn_pkg.sv
// Shared constants, state encoding and flit helpers for the NN move path.
// Reused by the router-side flit producer and the ttt encoder.
package ttt_nn_pkg;

  localparam int CELLS   = 9;
  localparam int SCORE_W = 7;
  localparam int FLIT_W  = CELLS * SCORE_W;
  localparam int IDX_W   = 4;

  localparam logic signed [SCORE_W-1:0] MIN_SCORE = -7'sd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cell i lives at bits [7i+6:7i]; out-of-range indices read as zero.
  function automatic logic signed [SCORE_W-1:0] score_slice(
    input logic [FLIT_W-1:0] flit,
    input logic [IDX_W-1:0]  idx
  );
    score_slice = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (idx == IDX_W'(i)) score_slice = flit[i*SCORE_W +: SCORE_W];
    end
  endfunction

endpackage

// File: rtl/nn_score_cmp.sv
// Decides whether a candidate cell replaces the current best: empty cell and
// either nothing found yet or a signed score >= best (ties go to later cells).
module nn_score_cmp
  import ttt_nn_pkg::*;
(
  input  logic signed [SCORE_W-1:0] cand,
  input  logic signed [SCORE_W-1:0] best,
  input  logic                      occupied,
  input  logic                      found,
  output logic                      take
);

  assign take = !occupied && (!found || (cand >= best));

endmodule

// File: rtl/nn_move_selector.sv
// Receives a 9-cell score flit, masks occupied cells and scans one cell per
// cycle for the best empty cell, then offers it over a valid/ready handshake.
module nn_move_selector
  import ttt_nn_pkg::*;
(
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      flit_valid,
  output logic                      flit_ready,
  input  logic [FLIT_W-1:0]         flit_data,
  input  logic [CELLS-1:0]          board_occ,
  output logic                      move_valid,
  input  logic                      move_ready,
  output logic [IDX_W-1:0]          move_idx,
  output logic signed [SCORE_W-1:0] move_score,
  output logic                      no_move,
  output logic                      busy
);

  state_t                    state;
  logic [FLIT_W-1:0]         flit_q;
  logic [CELLS-1:0]          occ_q;
  logic [IDX_W-1:0]          idx;
  logic signed [SCORE_W-1:0] best;
  logic [IDX_W-1:0]          best_idx;
  logic                      found;

  logic signed [SCORE_W-1:0] cand;
  logic                      cand_occ;
  logic                      take;

  assign cand     = score_slice(flit_q, idx);
  assign cand_occ = occ_q[idx];

  nn_score_cmp u_cmp (
    .cand     (cand),
    .best     (best),
    .occupied (cand_occ),
    .found    (found),
    .take     (take)
  );

  // DONE spends its first cycle registering the result, so move_valid rises
  // ten edges after the accepting edge and then holds until move_ready.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      flit_ready <= 1'b1;
      move_valid <= 1'b0;
      move_idx   <= '0;
      move_score <= '0;
      no_move    <= 1'b0;
      busy       <= 1'b0;
      flit_q     <= '0;
      occ_q      <= '0;
      idx        <= '0;
      best       <= MIN_SCORE;
      best_idx   <= '0;
      found      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flit_valid && flit_ready) begin
            flit_q     <= flit_data;
            occ_q      <= board_occ;
            idx        <= '0;
            found      <= 1'b0;
            best       <= MIN_SCORE;
            flit_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (take) begin
            best     <= cand;
            best_idx <= idx;
            found    <= 1'b1;
          end
          if (idx == IDX_W'(CELLS - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!move_valid) begin
            move_valid <= 1'b1;
            move_idx   <= found ? best_idx : '0;
            move_score <= found ? best : '0;
            no_move    <= !found;
          end else if (move_ready) begin
            move_valid <= 1'b0;
            flit_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          flit_ready <= 1'b1;
          busy       <= 1'b0;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_move_selector.sv
// Scoreboard bench for nn_move_selector: directed cases, stall, mid-scan reset
// and a back-to-back random stream.
module tb_nn_move_selector;

  logic              Clk = 1'b0;
  logic              reset;
  logic              flit_valid;
  logic              flit_ready;
  logic [62:0]       flit_data;
  logic [8:0]        board_occ;
  logic              move_valid;
  logic              move_ready;
  logic [3:0]        move_idx;
  logic signed [6:0] move_score;
  logic              no_move;
  logic              busy;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [3:0]        idx;
    logic signed [6:0] score;
    logic              nm;
  } exp_t;

  exp_t sb[$];

  nn_move_selector dut (
    .Clk        (Clk),
    .reset      (reset),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .flit_data  (flit_data),
    .board_occ  (board_occ),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_idx   (move_idx),
    .move_score (move_score),
    .no_move    (no_move),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [62:0] pack9(input int s[9]);
    logic [62:0] f;
    f = '0;
    for (int i = 0; i < 9; i++) f[i*7 +: 7] = 7'(s[i]);
    return f;
  endfunction

  // Reference selection: first empty cell always taken, ">=" lets later ties win.
  function automatic exp_t model(input logic [62:0] f, input logic [8:0] occ);
    exp_t e;
    bit found;
    logic signed [6:0] bestv;
    logic signed [6:0] s;
    logic [3:0] bi;
    found = 0;
    bestv = -7'sd64;
    bi = '0;
    for (int i = 0; i < 9; i++) begin
      s = f[i*7 +: 7];
      if (!occ[i] && (!found || s >= bestv)) begin
        bestv = s;
        bi = 4'(i);
        found = 1;
      end
    end
    e.idx   = found ? bi : 4'd0;
    e.score = found ? bestv : 7'sd0;
    e.nm    = !found;
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_flit(input logic [62:0] f, input logic [8:0] occ,
                           input exp_t e, input bit push);
    int n;
    n = 0;
    while (!flit_ready && n < 40) begin
      tick();
      n++;
    end
    if (!flit_ready) begin
      assertions++;
      failures++;
      $display("[TB] FAIL send_flit_ready_timeout: flit_ready=%0b required 1", flit_ready);
    end
    flit_data  = f;
    board_occ  = occ;
    flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_move(output int lat);
    lat = 0;
    while (!move_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    flit_valid = 1'b1;
    flit_data  = pack9('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    board_occ  = '0;
    move_ready = 1'b0;
    tick();
    tick();
    tick();
    assertions++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %0b required 0", busy);
    end
    assertions++;
    if (move_valid !== 1'b0 || move_idx !== 4'd0 || move_score !== 7'sd0 || no_move !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: valid=%0b idx=%0d score=%0d nm=%0b required 0/0/0/0",
               move_valid, move_idx, move_score, no_move);
    end
    assertions++;
    if (flit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_flit_ready: got %0b required 1", flit_ready);
    end
    reset      = 1'b0;
    flit_valid = 1'b0;
    tick();
    assertions++;
    if (busy !== 1'b0 || flit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_no_accept: busy=%0b ready=%0b required 0/1", busy, flit_ready);
    end
  endtask

  task automatic test_directed();
    int   sc[5][9];
    logic [8:0] occ[5];
    exp_t ex[5];
    exp_t e;
    int   lat;
    sc[0] = '{1, 2, 3, 4, 20, 5, 6, 7, 8};        occ[0] = 9'b000000000;
    sc[1] = '{1, 2, 3, 4, 20, 5, 6, 7, 8};        occ[1] = 9'b000010000;
    sc[2] = '{-5, -5, -5, -5, -5, -5, -5, -5, -5}; occ[2] = 9'b100000000;
    sc[3] = '{-64, -64, -64, -64, -64, -64, -64, -64, -64}; occ[3] = 9'b111111110;
    sc[4] = '{-64, -64, -64, -64, -64, -64, -64, -64, -64}; occ[4] = 9'h1FF;
    ex[0] = '{4'd4, 7'sd20, 1'b0};
    ex[1] = '{4'd8, 7'sd8, 1'b0};
    ex[2] = '{4'd7, -7'sd5, 1'b0};
    ex[3] = '{4'd0, -7'sd64, 1'b0};
    ex[4] = '{4'd0, 7'sd0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      send_flit(pack9(sc[c]), occ[c], ex[c], 1'b1);
      wait_move(lat);
      e = sb.pop_front();
      assertions++;
      if (lat != 10 || move_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL directed%0d_latency: got %0d valid=%0b required 10", c, lat, move_valid);
      end
      assertions++;
      if (move_idx !== e.idx || move_score !== e.score || no_move !== e.nm) begin
        failures++;
        $display("[TB] FAIL directed%0d_move: idx=%0d score=%0d nm=%0b required %0d/%0d/%0b",
                 c, move_idx, move_score, no_move, e.idx, e.score, e.nm);
      end
      move_ready = 1'b1;
      tick();
      move_ready = 1'b0;
      assertions++;
      if (flit_ready !== 1'b1 || move_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed%0d_release: ready=%0b valid=%0b busy=%0b required 1/0/0",
                 c, flit_ready, move_valid, busy);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   lat;
    bit   bad;
    send_flit(pack9('{3, -1, 9, 9, 0, 2, -7, 5, 1}), 9'b000000100, '{4'd3, 7'sd9, 1'b0}, 1'b1);
    // Disturb the inputs mid-scan: latched copies must win and this flit must be ignored.
    flit_data  = pack9('{60, 60, 60, 60, 60, 60, 60, 60, 60});
    board_occ  = 9'h000;
    tick();
    flit_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      assertions++;
      if (flit_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_scan_ready: got %0b required 0", flit_ready);
      end
      tick();
    end
    flit_valid = 1'b0;
    wait_move(lat);
    e = sb.pop_front();
    assertions++;
    if (lat != 6 || move_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_latency: got %0d valid=%0b required 6 more cycles", lat, move_valid);
    end
    for (int k = 0; k < 5; k++) begin
      assertions++;
      if (move_valid !== 1'b1 || move_idx !== e.idx || move_score !== e.score ||
          no_move !== e.nm || flit_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold: valid=%0b idx=%0d score=%0d ready=%0b busy=%0b required 1/%0d/%0d/0/1",
                 move_valid, move_idx, move_score, flit_ready, busy, e.idx, e.score);
      end
      tick();
    end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
    assertions++;
    if (flit_ready !== 1'b1 || move_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_release: ready=%0b valid=%0b required 1/0", flit_ready, move_valid);
    end
    bad = 0;
    for (int k = 0; k < 14; k++) begin
      if (move_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      tick();
    end
    assertions++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL stall_ignored_flit: extra activity seen, required none");
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [62:0] f;
    exp_t e;
    int   lat;
    bit   bad;
    f = pack9('{10, 11, 12, 13, 14, 15, 16, 17, 18});
    send_flit(f, 9'b0, model(f, 9'b0), 1'b0);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    assertions++;
    if (move_valid !== 1'b0 || move_idx !== 4'd0 || move_score !== 7'sd0 ||
        no_move !== 1'b0 || busy !== 1'b0 || flit_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_values: valid=%0b idx=%0d score=%0d nm=%0b busy=%0b ready=%0b required 0/0/0/0/0/1",
               move_valid, move_idx, move_score, no_move, busy, flit_ready);
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      if (move_valid !== 1'b0) bad = 1;
      tick();
    end
    assertions++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL midreset_no_move: move_valid pulsed, required never");
    end
    f = pack9('{-3, 7, -20, 7, 1, 0, 6, -64, 2});
    send_flit(f, 9'b000001000, model(f, 9'b000001000), 1'b1);
    wait_move(lat);
    e = sb.pop_front();
    assertions++;
    if (lat != 10 || move_valid !== 1'b1 || move_idx !== e.idx || move_score !== e.score || no_move !== e.nm) begin
      failures++;
      $display("[TB] FAIL midreset_recover: lat=%0d idx=%0d score=%0d nm=%0b required 10/%0d/%0d/%0b",
               lat, move_idx, move_score, no_move, e.idx, e.score, e.nm);
    end
    move_ready = 1'b1;
    tick();
    move_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [62:0] f;
    logic [8:0]  occ;
    exp_t e;
    int   lat;
    move_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      f = '0;
      for (int i = 0; i < 9; i++) f[i*7 +: 7] = 7'($urandom_range(0, 127));
      occ = (n == 5) ? 9'h1FF : 9'($urandom_range(0, 511));
      send_flit(f, occ, model(f, occ), 1'b1);
      wait_move(lat);
      e = sb.pop_front();
      assertions++;
      if (lat != 10 || move_valid !== 1'b1 || move_idx !== e.idx || move_score !== e.score || no_move !== e.nm) begin
        failures++;
        $display("[TB] FAIL b2b%0d: lat=%0d idx=%0d score=%0d nm=%0b required 10/%0d/%0d/%0b",
                 n, lat, move_idx, move_score, no_move, e.idx, e.score, e.nm);
      end
      tick();
      assertions++;
      if (move_valid !== 1'b0 || flit_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b%0d_handshake: valid=%0b ready=%0b required 0/1", n, move_valid, flit_ready);
      end
    end
    move_ready = 1'b0;
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    flit_valid = 1'b0;
    flit_data  = '0;
    board_occ  = '0;
    move_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
